// File: rtl/half_adder_pkg.sv
// Shared definitions for the half_adder arithmetic leaf: default width and
// the packed {carry, sum} result type.
package half_adder_pkg;

  localparam int HA_DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                        carry;
    logic [HA_DEFAULT_WIDTH-1:0] sum;
  } ha_result_t;

endpackage

// File: rtl/ha_add_core.sv
// Purely combinational WIDTH-bit unsigned add; the top wraps it with the
// register stage.
module ha_add_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result
);

  // Zero-extend both operands so the wrap-around lands in bit WIDTH.
  assign result = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-bit adder producing {carry, sum} one cycle after in_valid.
// Define HALF_ADDER_FLAGS_EN to add the registered zero flag output.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             carry,
  output logic [WIDTH-1:0] sum
`ifdef HALF_ADDER_FLAGS_EN
  ,
  output logic             zero
`endif
);

  // Handshake: in_valid qualifies a/b for one cycle and there is no ready;
  // every accepted pair yields exactly one out_valid pulse one cycle later,
  // and carry/sum hold their last value whenever out_valid is low.

  logic [WIDTH:0] result;

  ha_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      carry     <= 1'b0;
      sum       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        carry <= result[WIDTH];
        sum   <= result[WIDTH-1:0];
      end
    end
  end

`ifdef HALF_ADDER_FLAGS_EN
  // Reset value is 1 because the cleared result {0, 0} is itself zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero <= 1'b1;
    end else if (in_valid) begin
      zero <= (result == '0);
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: the driver pushes hand-computed results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_half_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         carry;
  logic [W-1:0] sum;
`ifdef HALF_ADDER_FLAGS_EN
  logic         zero;
`endif

  logic [W:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  half_adder #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .carry     (carry),
`ifdef HALF_ADDER_FLAGS_EN
    .zero      (zero),
`endif
    .sum       (sum)
  );

  // Clock and initial reset drive
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'hF;
    b        = 4'hF;
  end

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Present one cycle of inputs, then return just after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W:0] exp);
    rst_n    = r;
    in_valid = v;
    a        = va;
    b        = vb;
    if (r && v) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_out_valid"}, {{W{1'b0}}, out_valid}, '0);
    chk({name, "_result"}, {carry, sum}, '0);
`ifdef HALF_ADDER_FLAGS_EN
    chk({name, "_zero"}, {{W{1'b0}}, zero}, 5'd1);
`endif
  endtask

  // Monitor: pop and compare on every presented result
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_out_valid: got result %h, want no output", {carry, sum});
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {carry, sum}, e);
`ifdef HALF_ADDER_FLAGS_EN
        chk("zero_flag", {{W{1'b0}}, zero}, {{W{1'b0}}, (e == '0)});
`endif
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int wait_cycles;
    @(posedge clk);
    #1;

    // Reset held with in_valid=1, a=b=F
    step(1'b0, 1'b1, 4'hF, 4'hF, 5'h00);
    chk_cleared("reset_1");
    step(1'b0, 1'b1, 4'hF, 4'hF, 5'h00);
    chk_cleared("reset_2");

    // Basic add, then hold with don't-care operands
    step(1'b1, 1'b1, 4'h3, 4'h4, 5'h07);
    chk("basic_out_valid", {{W{1'b0}}, out_valid}, 5'd1);
    step(1'b1, 1'b0, 4'hA, 4'hA, 5'h00);
    chk("hold_out_valid", {{W{1'b0}}, out_valid}, 5'd0);
    chk("hold_result", {carry, sum}, 5'h07);
    step(1'b1, 1'b0, 4'bxxxx, 4'bxxxx, 5'h00);
    chk("hold_x_result", {carry, sum}, 5'h07);

    // Overflow and zero-result vectors, back to back
    step(1'b1, 1'b1, 4'h9, 4'hB, 5'h14);
    step(1'b1, 1'b1, 4'hF, 4'h1, 5'h10);
    step(1'b1, 1'b1, 4'h0, 4'h0, 5'h00);
    step(1'b1, 1'b1, 4'hF, 4'hF, 5'h1E);
    step(1'b1, 1'b0, 4'h0, 4'h0, 5'h00);

    // Reset mid-stream overrides in_valid on the same edge
    step(1'b1, 1'b1, 4'h5, 4'h6, 5'h0B);
    step(1'b0, 1'b1, 4'h8, 4'h8, 5'h00);
    chk_cleared("midreset");
    step(1'b1, 1'b1, 4'h1, 4'h1, 5'h02);
    chk("post_reset_out_valid", {{W{1'b0}}, out_valid}, 5'd1);
    chk("post_reset_result", {carry, sum}, 5'h02);

    // 20 back-to-back random pairs; a mismatch ends the run early
    for (int i = 0; i < 20; i++) begin
      if (n_fail != 0) break;
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      step(1'b1, 1'b1, ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    step(1'b1, 1'b0, 4'h0, 4'h0, 5'h00);

    // Drain: every pushed expectation must have been presented
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    chk("drain_pending", 5'(exp_q.size()), 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
